// File: rtl/trigtimer_pkg.sv
// Shared encodings for the trigger timer register slave: FSM states,
// CTRL bit positions, DATA register length and default bus addresses.
package trigtimer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HIGH  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int CTRL_ARM = 0;
    localparam int CTRL_CLR = 1;
    localparam int CTRL_OVF = 2;

    localparam int DATA_LEN = 8;

    localparam logic [5:0] ADDR_CTRL_DEF = 6'd50;
    localparam logic [5:0] ADDR_DATA_DEF = 6'd51;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, followed by a history
// flop so rising and falling edges are detected on the synchronized signal.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Shift the raw input through the synchronizer chain, then keep one
    // cycle of history of the synchronized level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/reg_trigtimer.sv
// Register-bus slave that measures arm-to-trigger delay and the high time of
// the first trigger pulse, both in clk cycles, with saturating counters and a
// snapshot shadow so multi-byte reads of the result are never torn.
module reg_trigtimer
    import trigtimer_pkg::*;
#(
    parameter logic [5:0] ADDR_CTRL   = ADDR_CTRL_DEF,
    parameter logic [5:0] ADDR_DATA   = ADDR_DATA_DEF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  reg_address,
    input  logic [15:0] reg_bytecnt,
    input  logic [7:0]  reg_datai,
    output logic [7:0]  reg_datao,
    input  logic [15:0] reg_size,
    input  logic        reg_read,
    input  logic        reg_write,
    input  logic        reg_addrvalid,
    input  logic [5:0]  reg_hypaddress,
    output logic [15:0] reg_hyplen,
    input  logic        trigger_i,
    output logic        busy_o,
    output logic        done_o
);

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] delay_cnt, delay_d;
    logic [31:0] width_cnt, width_d;
    logic        ovf_q, ovf_d;
    logic        done_d;
    logic [63:0] shadow_q;
    logic        trig_level, trig_rise, trig_fall;

    logic        ctrl_wr;
    logic        rd_ctrl, rd_data;
    logic [63:0] snap;
    logic [7:0]  datao_d;
    logic [15:0] hyplen_d;

    logic        unused_ok;
    assign unused_ok = ^{reg_size, reg_datai[7:2], trig_level};

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (trigger_i),
        .level  (trig_level),
        .rise   (trig_rise),
        .fall   (trig_fall)
    );

    assign ctrl_wr = reg_write & reg_addrvalid & (reg_address == ADDR_CTRL) &
                     (reg_bytecnt == 16'd0);

    // Next-state and counter update; clear beats arm, and both override the FSM.
    always_comb begin
        state_d = state_q;
        delay_d = delay_cnt;
        width_d = width_cnt;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        if (ctrl_wr && reg_datai[CTRL_CLR]) begin
            state_d = ST_IDLE;
            delay_d = '0;
            width_d = '0;
            ovf_d   = 1'b0;
        end else if (ctrl_wr && reg_datai[CTRL_ARM]) begin
            state_d = ST_ARMED;
            delay_d = '0;
            width_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    // The rise cycle itself still counts toward delay.
                    delay_d = sat_inc(delay_cnt);
                    if (delay_d == 32'hFFFF_FFFF) ovf_d = 1'b1;
                    if (trig_rise) begin
                        state_d = ST_HIGH;
                        width_d = 32'd1;
                    end
                end
                ST_HIGH: begin
                    if (trig_fall) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        width_d = sat_inc(width_cnt);
                        if (width_d == 32'hFFFF_FFFF) ovf_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Measurement state, counters and the registered done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            delay_cnt <= '0;
            width_cnt <= '0;
            ovf_q     <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            state_q   <= state_d;
            delay_cnt <= delay_d;
            width_cnt <= width_d;
            ovf_q     <= ovf_d;
            done_o    <= done_d;
        end
    end

    assign busy_o = (state_q == ST_ARMED) || (state_q == ST_HIGH);

    // Read mux: byte 0 of DATA takes a fresh snapshot, later bytes use the shadow.
    always_comb begin
        rd_ctrl  = reg_read & reg_addrvalid & (reg_address == ADDR_CTRL);
        rd_data  = reg_read & reg_addrvalid & (reg_address == ADDR_DATA);
        snap     = (reg_bytecnt == 16'd0) ? {width_cnt, delay_cnt} : shadow_q;
        datao_d  = 8'h00;
        if (rd_ctrl) begin
            datao_d = {5'b00000, ovf_q, state_q};
        end else if (rd_data && (reg_bytecnt < 16'(DATA_LEN))) begin
            datao_d = snap[{reg_bytecnt[2:0], 3'b000} +: 8];
        end
        hyplen_d = 16'd0;
        if (reg_hypaddress == ADDR_CTRL)      hyplen_d = 16'd1;
        else if (reg_hypaddress == ADDR_DATA) hyplen_d = 16'(DATA_LEN);
    end

    // Registered bus outputs and the snapshot shadow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_datao  <= 8'h00;
            reg_hyplen <= 16'd0;
            shadow_q   <= '0;
        end else begin
            reg_datao  <= datao_d;
            reg_hyplen <= hyplen_d;
            if (rd_data && (reg_bytecnt == 16'd0)) shadow_q <= {width_cnt, delay_cnt};
        end
    end

endmodule
